muldiv_sequencer: RTL and testbench

- Multi-cycle controller and datapath for RV32M multiply/divide in the 5-stage pipeline, sitting in the Execute stage beside the single-cycle ALU.
- Accepts an M-extension op (selected by funct3) and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Holds the pipeline via stall while running, then presents a one-cycle done/result for Execute to capture.

---
 rtl/muldiv_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M multiply/divide unit living beside the ALU in Execute.
// Multiplies with a shift-add over a 2*XLEN accumulator and divides with a
// restoring algorithm, one bit per cycle, on operand magnitudes; signs are
// fixed up in a final cycle. The pipeline is held through stall until the
// one-cycle done pulse presents the registered result.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN  divide by zero, signed overflow and multiply by
//                        zero go straight from IDLE to FIX (2-cycle path).
//                        Result values are identical with or without it.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    valid M-extension op present in Execute
//   flush    kill any in-flight op (no done, result kept)
//   funct3   op select: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   src_a    rs1 operand (multiplicand / dividend)
//   src_b    rs2 operand (multiplier / divisor)
//   busy     unit is not idle
//   stall    hold IF/ID/EX pipeline registers
//   done     one-cycle pulse, result valid
//   result   registered result, held until the next done

module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W   = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [2:0]        op_q;
  logic              neg_a_q, neg_b_q;
  logic              div_zero_q, overflow_q, zero_prod_q;

  logic              accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, overflow, zero_prod, skip_calc;
  logic [XLEN-1:0]   abs_a, abs_b;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  // Operand decode at the accept point. MULHSU treats src_b as unsigned and
  // MULHU/DIVU/REMU treat both operands as unsigned. The special cases are
  // recognised here so FIX can override the iterative datapath.
  always_comb begin
    is_div    = funct3[2];
    a_signed  = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed  = is_div ? ~funct3[0] : ~funct3[1];
    a_neg     = a_signed & src_a[XLEN-1];
    b_neg     = b_signed & src_b[XLEN-1];
    abs_a     = a_neg ? -src_a : src_a;
    abs_b     = b_neg ? -src_b : src_b;
    div_zero  = is_div & (src_b == '0);
    overflow  = is_div & ~funct3[0] & (src_a == MIN_NEG) & (src_b == '1);
    zero_prod = ~is_div & ((src_a == '0) | (src_b == '0));
    accept    = (state == IDLE) & start & ~flush;
`ifdef MULDIV_EARLY_OUT_EN
    skip_calc = div_zero | overflow | zero_prod;
`else
    skip_calc = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and handshake outputs. stall covers the accept cycle too so
  // the op stays in EX, but drops in DONE so EX/MEM captures the result.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) state_nxt = skip_calc ? FIX : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (count == CNT_W'(1)) state_nxt = FIX;
      end
      FIX: begin
        stall     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // One iteration. Multiply: acc = {high, multiplier}, add the multiplicand
  // into the high half when the low bit is set, then shift right.
  // Divide: acc = {partial remainder, dividend}; shift one dividend bit into
  // the remainder and subtract the divisor; a borrow restores.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
    if (op_q[2]) begin
      if (div_diff[XLEN+1]) acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                  acc_step = {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign correction and result selection. The magnitudes in acc are fixed
  // up here; divide-by-zero and signed overflow are forced regardless of
  // what the iterations produced.
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc : acc;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (div_zero_q) begin
      quo_fix = '1;
      rem_fix = neg_a_q ? -opa : opa;
    end else if (overflow_q) begin
      quo_fix = MIN_NEG;
      rem_fix = '0;
    end
    case (op_q)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
    if (zero_prod_q) fix_result = '0;
  end

  // Datapath registers. Operands and funct3 are captured only on accept;
  // a flush just clears the counter and leaves result untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      acc         <= '0;
      opa         <= '0;
      opb         <= '0;
      op_q        <= '0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
      zero_prod_q <= 1'b0;
      result      <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q        <= funct3;
            neg_a_q     <= a_neg;
            neg_b_q     <= b_neg;
            div_zero_q  <= div_zero;
            overflow_q  <= overflow;
            zero_prod_q <= zero_prod;
            opa         <= abs_a;
            opb         <= abs_b;
            acc         <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
            count       <= CNT_W'(XLEN);
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count - 1'b1;
        end
        FIX: begin
          result <= fix_result;
          count  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: table of directed vectors, hand-written
// multi-cycle sequences (held start, flush, async reset) and randomized ops
// checked against a plain-arithmetic RV32M reference model.

module tb_muldiv_sequencer;

  localparam int          XLEN    = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int vectors     = 0;
  int miscompares = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .flush   (flush),
    .funct3  (funct3),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  // RV32M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Clock edges from the accept edge to the cycle in which done is high
  function automatic int expLat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f3[2] && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    if (!f3[2] && (a == 32'd0 || b == 32'd0)) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Called just after the accept edge; samples at negedges until done.
  task automatic waitDone(output int lat, output int stallCnt, output logic [31:0] res);
    lat      = -1;
    stallCnt = 0;
    res      = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        res = result;
        checkOutput("stall_low_in_done", {31'b0, stall}, 32'd0);
        break;
      end
      if (stall) stallCnt++;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output int stallCnt);
    @(negedge clk);
    checkOutput("idle_before_start", {31'b0, busy}, 32'd0);
    funct3 = f3;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    flush  = 1'b0;
    #1;
    checkOutput("stall_on_accept", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    src_a  = $urandom;
    src_b  = $urandom;
    waitDone(lat, stallCnt, res);
  endtask

  task automatic runAndCheck(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int          lat, stallCnt, el;
    el = expLat(f3, a, b);
    applyStimulus(f3, a, b, res, lat, stallCnt);
    checkOutput({name, "_result"}, res, exp);
    checkOutput({name, "_latency"}, 32'(lat), 32'(el));
    checkOutput({name, "_stall_cycles"}, 32'(stallCnt), 32'(el));
  endtask

  initial begin
    logic [31:0] res, ra, rb;
    logic [2:0]  rf;
    int          lat, stallCnt, doneCnt;

    reset_n = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    funct3  = 3'd0;
    src_a   = 32'd0;
    src_b   = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy",   {31'b0, busy},  32'd0);
    checkOutput("reset_done",   {31'b0, done},  32'd0);
    checkOutput("reset_stall",  {31'b0, stall}, 32'd0);
    checkOutput("reset_result", result,         32'd0);
    reset_n = 1'b1;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[5]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[11] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[12] = '{3'd0, 32'd0,         32'h1234_5678, 32'd0};
    vecs[13] = '{3'd3, 32'h1234_5678, 32'd0,         32'd0};

    for (int i = 0; i < 14; i++)
      runAndCheck($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start held high across a whole op: ignored while busy, then the
    // operands present at the next IDLE cycle are taken.
    @(negedge clk);
    funct3 = 3'd0;
    src_a  = 32'd9;
    src_b  = 32'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    src_a = 32'd2;
    src_b = 32'd3;
    waitDone(lat, stallCnt, res);
    checkOutput("held_start_result",  res,         32'd45);
    checkOutput("held_start_latency", 32'(lat),    32'(XLEN + 1));
    @(negedge clk);
    checkOutput("held_start_idle_busy",  {31'b0, busy},  32'd0);
    checkOutput("held_start_idle_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat, stallCnt, res);
    checkOutput("second_op_result",  res,      32'd6);
    checkOutput("second_op_latency", 32'(lat), 32'(XLEN + 1));

    // flush in the 10th CALC cycle of a DIVU
    @(negedge clk);
    funct3 = 3'd5;
    src_a  = 32'd100;
    src_b  = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    doneCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("flush_no_done",     32'(doneCnt), 32'd0);
    checkOutput("flush_result_kept", result,       32'd6);

    // flush wins over start in IDLE
    @(negedge clk);
    funct3 = 3'd0;
    src_a  = 32'd3;
    src_b  = 32'd3;
    start  = 1'b1;
    flush  = 1'b1;
    #1;
    checkOutput("flush_beats_start_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    checkOutput("flush_beats_start_busy", {31'b0, busy}, 32'd0);
    start = 1'b0;
    flush = 1'b0;

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    funct3 = 3'd0;
    src_a  = 32'd5;
    src_b  = 32'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_busy",   {31'b0, busy}, 32'd0);
    checkOutput("async_reset_done",   {31'b0, done}, 32'd0);
    checkOutput("async_reset_result", result,        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    runAndCheck("mul_after_reset", 3'd0, 32'd3, 32'd4, 32'h0000_000C);

    // randomized ops, biased toward the interesting operand values
    for (int n = 0; n < 150; n++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       ra = 32'd0;
        1:       ra = MIN_NEG;
        2:       ra = 32'hFFFF_FFFF;
        3:       ra = $urandom_range(0, 20);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = MIN_NEG;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      runAndCheck($sformatf("rand%0d_f%0d", n, rf), rf, ra, rb, refModel(rf, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
